// File: rtl/bmac_sign_packer.sv
`default_nettype none
// ============================================================================
//  Module      : bmac_sign_packer
//  Description : Binarizes a stream of signed accumulator results against a
//                per-element threshold (1 = +1, 0 = -1). The resulting sign
//                bits are packed LSB-first into PACK_W-bit words for the next
//                layer's XNOR/popcount datapath. This is the encoder-side
//                inverse of the popcount-to-bipolar-sum lookup table.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       clock
//    rst        in   1       synchronous active-high reset
//    thresh     in   DATA_W  signed threshold, sampled on each accepted element
//    in_valid   in   1       input element valid
//    in_ready   out  1       block can accept an element
//    in_data    in   DATA_W  signed accumulator value
//    in_last    in   1       element ends the vector; flushes a partial word
//    out_valid  out  1       packed word valid
//    out_ready  in   1       downstream accepts the word
//    out_data   out  PACK_W  packed sign bits, bit i = i-th element of the word
//    out_mask   out  PACK_W  1 for every bit position filled by a real element
//    out_last   out  1       word ends a vector
// ============================================================================
module bmac_sign_packer #(
    parameter int DATA_W  = 16,
    parameter int PACK_W  = 8,
    parameter bit PAD_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK_W-1:0] out_data,
    output logic [PACK_W-1:0] out_mask,
    output logic              out_last
);

    // Bit-position counter width; a one-bit word still needs a 1-bit counter.
    localparam int c_idx_w = (PACK_W > 1) ? $clog2(PACK_W) : 1;

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PACK_W - 1);
    localparam logic [c_idx_w-1:0] c_idx_zero = '0;
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [PACK_W-1:0]  c_pad_word = {PACK_W{PAD_VAL}};

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    logic [PACK_W-1:0]  r_pack;       // sign bits collected so far
    logic [c_idx_w-1:0] r_idx;        // position of the next element
    logic               r_out_valid;
    logic [PACK_W-1:0]  r_out_data;
    logic [PACK_W-1:0]  r_out_mask;
    logic               r_out_last;

    // ------------------------------------------------------------------------
    // Handshake and binarization
    // ------------------------------------------------------------------------
    logic               w_in_ready;
    logic               w_accept;
    logic               w_xfer;
    logic               w_bit;
    logic               w_complete;
    logic [PACK_W-1:0]  w_word_next;
    logic [PACK_W-1:0]  w_mask_next;

    // The output register is the only storage for finished words, so a new
    // element may enter only when that register is empty or draining now.
    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;
    assign w_xfer     = r_out_valid & out_ready;

    // Full-width two's-complement compare; ties count as +1.
    assign w_bit      = ($signed(in_data) >= $signed(thresh));

    // A word closes on the last bit position or when the vector ends early.
    assign w_complete = w_accept & ((r_idx == c_last_idx) | in_last);

    // ------------------------------------------------------------------------
    // Word assembly: positions below the current index come from the packing
    // register, the current position takes the incoming bit, and everything
    // above it is padding. The mask marks positions 0..idx as real elements.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < PACK_W; gi++) begin : g_word
        localparam logic [c_idx_w-1:0] c_pos = c_idx_w'(gi);

        assign w_mask_next[gi] = (c_pos <= r_idx);
        assign w_word_next[gi] = (c_pos == r_idx) ? w_bit      :
                                 (c_pos <  r_idx) ? r_pack[gi] :
                                                    PAD_VAL;
    end

    // ------------------------------------------------------------------------
    // Packing register and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Any partial word and any pending output word are discarded.
            r_pack      <= c_pad_word;
            r_idx       <= c_idx_zero;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_complete) begin
                // Loading while the previous word transfers keeps out_valid
                // high, giving one element per cycle with no bubble.
                r_out_data  <= w_word_next;
                r_out_mask  <= w_mask_next;
                r_out_last  <= in_last;
                r_out_valid <= 1'b1;
                r_idx       <= c_idx_zero;
                r_pack      <= c_pad_word;
            end else begin
                if (w_accept) begin
                    r_pack[r_idx] <= w_bit;
                    r_idx         <= r_idx + c_idx_one;
                end
                if (w_xfer) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_mask  = r_out_mask;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_bmac_sign_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bmac_sign_packer
//  Description : Self-checking bench for bmac_sign_packer. Two instances
//                (PAD_VAL = 0 and PAD_VAL = 1) share one stimulus stream and
//                are compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bmac_sign_packer;

    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] thresh;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_ready;

    logic          in_ready,  in_ready_p1;
    logic          out_valid, out_valid_p1;
    logic [PW-1:0] out_data,  out_data_p1;
    logic [PW-1:0] out_mask,  out_mask_p1;
    logic          out_last,  out_last_p1;

    always #5 clk = ~clk;

    bmac_sign_packer #(.DATA_W(DW), .PACK_W(PW), .PAD_VAL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_last  (out_last)
    );

    bmac_sign_packer #(.DATA_W(DW), .PACK_W(PW), .PAD_VAL(1'b1)) dut_p1 (
        .clk       (clk),
        .rst       (rst),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready_p1),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_p1),
        .out_ready (out_ready),
        .out_data  (out_data_p1),
        .out_mask  (out_mask_p1),
        .out_last  (out_last_p1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: accepted sign bits wait in a queue until the word is
    // full or the vector ends, then become the pending output word.
    // ------------------------------------------------------------------------
    bit            mq[$];
    logic          m_valid;
    logic [PW-1:0] m_d0, m_d1, m_mask;
    logic          m_last;
    int            m_sum;            // sum of the +1/-1 elements of the word

    typedef struct packed {
        logic [PW-1:0] d0;
        logic [PW-1:0] d1;
        logic [PW-1:0] m;
        logic          l;
    } word_t;
    word_t obs[$];                   // words observed leaving the DUTs

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_d0    = '0;
        m_d1    = '0;
        m_mask  = '0;
        m_last  = 1'b0;
        m_sum   = 0;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // advance the model to what the next rising edge must produce.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l,
                         input logic [DW-1:0] th, input bit ordy, input bit r);
        bit acc;
        bit xfer;
        bit b;
        int pos;
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        thresh    = th;
        out_ready = ordy;
        @(negedge clk);
        check_val("in_ready",     in_ready,     (!m_valid) || ordy);
        check_val("in_ready_p1",  in_ready_p1,  (!m_valid) || ordy);
        check_val("out_valid",    out_valid,    m_valid);
        check_val("out_valid_p1", out_valid_p1, m_valid);
        if (m_valid) begin
            check_val("out_data",    out_data,    m_d0);
            check_val("out_data_p1", out_data_p1, m_d1);
            check_val("out_mask",    out_mask,    m_mask);
            check_val("out_mask_p1", out_mask_p1, m_mask);
            check_val("out_last",    out_last,    m_last);
            if (m_mask == {PW{1'b1}})
                check_val("roundtrip", 2 * $countones(out_data) - PW, m_sum);
        end
        if (out_valid && ordy)
            obs.push_back('{d0: out_data, d1: out_data_p1, m: out_mask, l: out_last});

        if (r) begin
            model_reset();
        end else begin
            acc  = v && (!m_valid || ordy);
            xfer = m_valid && ordy;
            if (acc) begin
                b = (int'($signed(d)) >= int'($signed(th)));
                mq.push_back(b);
                if (mq.size() == PW || l) begin
                    m_d0   = '0;
                    m_d1   = '1;
                    m_mask = '0;
                    m_sum  = 0;
                    pos    = 0;
                    foreach (mq[k]) begin
                        m_d0[pos]   = mq[k];
                        m_d1[pos]   = mq[k];
                        m_mask[pos] = 1'b1;
                        m_sum       = m_sum + (mq[k] ? 1 : -1);
                        pos++;
                    end
                    m_last  = l;
                    m_valid = 1'b1;
                    mq.delete();
                end else if (xfer) begin
                    m_valid = 1'b0;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    // Pops the next observed word and compares it with fixed expectations.
    task automatic expect_word(input string tag, input logic [PW-1:0] d0,
                               input logic [PW-1:0] d1, input logic [PW-1:0] m,
                               input logic l);
        word_t w;
        if (obs.size() == 0) begin
            check_val({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            w = obs.pop_front();
            check_val({tag, "_data"},    w.d0, d0);
            check_val({tag, "_data_p1"}, w.d1, d1);
            check_val({tag, "_mask"},    w.m,  m);
            check_val({tag, "_last"},    w.l,  l);
        end
    endtask

    initial begin
        logic [DW-1:0] th_r;
        model_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        thresh = '0; out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        rst = 1'b0;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data",  out_data,  0);
        check_val("rst_out_mask",  out_mask,  0);
        check_val("rst_out_last",  out_last,  0);
        check_val("rst_in_ready",  in_ready,  1);

        // Full word: -8..6 step 2 against 0 gives 8'hF0
        obs.delete();
        for (int k = 0; k < 8; k++)
            cycle(1'b1, DW'(-8 + 2 * k), 1'b0, '0, 1'b1, 1'b0);
        idle(2);
        expect_word("full", 8'hF0, 8'hF0, 8'hFF, 1'b0);

        // Partial flush: 5, -1, 7 with in_last on the third element
        obs.delete();
        cycle(1'b1, DW'(5),  1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, DW'(-1), 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, DW'(7),  1'b1, '0, 1'b1, 1'b0);
        idle(2);
        expect_word("partial", 8'h05, 8'hFD, 8'h07, 1'b1);

        // Backpressure: stall for 5 cycles with an element waiting
        obs.delete();
        for (int k = 0; k < 8; k++)
            cycle(1'b1, DW'(100), 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            cycle(1'b1, DW'(-1), 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            cycle(1'b1, (k % 2) ? DW'(1) : DW'(-1), 1'b0, '0, 1'b1, 1'b0);
        idle(2);
        expect_word("bp_first",  8'hFF, 8'hFF, 8'hFF, 1'b0);
        expect_word("bp_second", 8'hAA, 8'hAA, 8'hFF, 1'b0);

        // Back-to-back throughput: 32 elements, 4 words, no stalls
        obs.delete();
        for (int k = 0; k < 32; k++)
            cycle(1'b1, DW'($urandom), 1'b0, DW'($urandom), 1'b1, 1'b0);
        idle(2);
        check_val("tput_words", obs.size(), 4);

        // Signed boundaries as one-element words
        obs.delete();
        cycle(1'b1, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0);
        cycle(1'b1, 16'h7FFE, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        cycle(1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        idle(2);
        expect_word("bnd_min", 8'h01, 8'hFF, 8'h01, 1'b1);
        expect_word("bnd_max", 8'h00, 8'hFE, 8'h01, 1'b1);
        expect_word("bnd_m1",  8'h01, 8'hFF, 8'h01, 1'b1);

        // Reset mid-word discards the partial word
        obs.delete();
        for (int k = 0; k < 3; k++)
            cycle(1'b1, DW'(-50), 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++)
            cycle(1'b1, DW'(10), 1'b0, '0, 1'b1, 1'b0);
        check_val("rstmid_quiet", obs.size(), 0);
        cycle(1'b1, DW'(10), 1'b0, '0, 1'b1, 1'b0);
        idle(2);
        check_val("rstmid_words", obs.size(), 1);
        expect_word("rstmid", 8'hFF, 8'hFF, 8'hFF, 1'b0);

        // Randomized traffic with random stalls, ends and thresholds
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0:       th_r = 16'h8000;
                1:       th_r = 16'h7FFF;
                default: th_r = DW'($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) == 0,
                  th_r, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bmac_sign_packer.md
Name: bmac_sign_packer

Overview:
- Encoder-side counterpart of the popcount-to-bipolar-sum lookup table. That table takes a packed 8-bit binary activation word and returns a sign-extended bipolar sum, 2·popcount − 8.
- This block goes the other way. It takes a stream of signed accumulator results, binarizes each one against a threshold (1 = +1, 0 = −1), and packs the bits LSB-first into PACK_W-bit words.
- Its output words feed the next layer's XNOR/popcount datapath.
- Valid/ready streaming on both sides. A single-entry output register provides backpressure.

Parameters:
- DATA_W, 16, width of signed input values and threshold; matches the 16-bit sum width.
- PACK_W, 8, bits per packed output word; matches the 8-bit popcount input.
- PAD_VAL, 0, value placed in unfilled bit positions of a partial word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- thresh  in  DATA_W  signed threshold, sampled per element on acceptance
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  DATA_W  signed accumulator value
- in_last  in  1  element ends the current vector; flushes a partial word
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts word
- out_data  out  PACK_W  packed sign bits; bit i = i-th accepted element of the word
- out_mask  out  PACK_W  1 for each bit position filled by a real element
- out_last  out  1  word ends a vector

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Handshakes:
  - Input accept: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. This is combinational from out_ready and is the only comb path.
- Binarize: bit = (signed in_data >= signed thresh). Full DATA_W signed compare; no truncation.
- Internal state:
  - pack_q, PACK_W bits.
  - idx counter, range 0..PACK_W-1, width clog2(PACK_W).
- On accept:
  - pack_q[idx] <= bit.
  - If idx == PACK_W-1 or in_last: word complete.
  - Otherwise idx <= idx+1.
- On word complete, in the same edge:
  - out_data <= pack_q with bit idx replaced by the new bit; positions > idx are set to PAD_VAL.
  - out_mask <= bits 0..idx set.
  - out_last <= in_last.
  - out_valid <= 1.
  - idx <= 0; pack_q <= all PAD_VAL.
- Latency: out_valid asserts the cycle after the completing element is accepted.
- Output transfer without a simultaneous completion: out_valid <= 0.
- Simultaneous transfer and completion (out_valid & out_ready & completing accept): the new word is loaded and out_valid stays 1. No bubble; full throughput of one element per cycle.
- Stall: while out_valid & ~out_ready:
  - in_ready = 0.
  - out_data, out_mask and out_last are held stable.
  - No internal state changes.
- in_last with idx == PACK_W-1 gives a full word: out_mask all ones, out_last = 1.
- in_last on the first element gives out_mask = 1, with bits 1..PACK_W-1 equal to PAD_VAL.
- Consecutive in_last elements each produce a one-bit word.
- Inputs while in_valid = 0 are ignored; thresh is don't-care when not accepting.
- Reset values:
  - out_valid = 0, out_data = 0, out_mask = 0, out_last = 0.
  - idx = 0, pack_q = PAD_VAL.
  - in_ready = 1 in the cycle after reset.
- Reset mid-word: the partial word is discarded and nothing is emitted. A pending output word is dropped.
- Round-trip property: a full word fed to the lookup table yields 2·popcount(out_data) − 8, equal to the sum of the bipolar elements.

Test Plan:
- Full word:
  - Stimulus: thresh=0, out_ready=1, in_data = −8,−6,−4,−2,0,2,4,6 on consecutive cycles.
  - Response: one cycle after the 8th accept, out_valid=1, out_data=8'hF0, out_mask=8'hFF, out_last=0.
  - Round-trip: the lookup of 8'hF0 gives 0.
- Partial flush:
  - Stimulus: thresh=0, in_data 5, −1, 7 with in_last on the 3rd element.
  - Response: out_data=8'h05, out_mask=8'h07, out_last=1. With PAD_VAL=1, out_data=8'hFD.
- Backpressure:
  - Stimulus: hold out_ready=0 after a word completes; keep in_valid=1.
  - Response: in_ready=0; out_data is stable over 5 cycles; no element is lost. Raising out_ready transfers the word, and the next elements are accepted in the same cycle.
- Back-to-back throughput:
  - Stimulus: out_ready=1 constantly, 32 continuous elements.
  - Response: 4 words on cycles 9, 17, 25, 33 after the first accept; in_ready never deasserts.
- Signed boundaries:
  - thresh=−32768, in_data=−32768 → bit 1.
  - thresh=32767, in_data=32766 → bit 0.
  - thresh=−1, in_data=0 → bit 1.
- Reset mid-word:
  - Stimulus: accept 3 elements, pulse rst for 1 cycle, then feed 8 elements all ≥ thresh.
  - Response: no output during or after reset until the 8th element; then a single word with out_data=8'hFF, out_mask=8'hFF.
